// File: rtl/conv_idx_sequencer.sv
// Index/strobe sequencer for the convolution engine: walks z[i] = sum x[j]*y[i-j]
// and drives X/Y read addresses, MAC clear/enable and Z write strobes.
//
// state | meaning
// IDLE  | waiting for start_i, sizes latched on acceptance
// INIT  | clear accumulator, compute j range for output i
// READ  | issue one X/Y address pair per term
// FLUSH | accumulate the last term returned by memory
// WRITE | write accumulator to Z[i]
// DONE  | one-cycle completion pulse
module conv_idx_sequencer #(
    parameter int AW = 5,
    parameter int ZW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [AW-1:0] size_x_i,
    input  logic [AW-1:0] size_y_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW-1:0] addr_x_o,
    output logic [AW-1:0] addr_y_o,
    output logic          mac_clr_o,
    output logic          mac_en_o,
    output logic          wr_z_o,
    output logic [ZW-1:0] addr_z_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        READ  = 3'd2,
        FLUSH = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t        state;
    logic [AW-1:0] sz_x;
    logic [AW-1:0] sz_y;
    logic [AW-1:0] j;
    logic [AW-1:0] j_hi;
    logic [ZW-1:0] i;

    logic [ZW-1:0] sz_x_w;
    logic [ZW-1:0] sz_y_w;
    logic [ZW-1:0] last_i;
    logic [ZW-1:0] j_lo_w;
    logic [ZW-1:0] j_hi_w;
    logic [AW-1:0] j_inc;

    // All index math is done ZW wide; results are known to fit AW bits.
    assign sz_x_w = ZW'(sz_x);
    assign sz_y_w = ZW'(sz_y);
    assign last_i = sz_x_w + sz_y_w - ZW'(2);
    assign j_lo_w = (i >= sz_y_w) ? (i - sz_y_w + ZW'(1)) : '0;
    assign j_hi_w = (i < sz_x_w - ZW'(1)) ? i : (sz_x_w - ZW'(1));
    assign j_inc  = j + AW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sz_x      <= '0;
            sz_y      <= '0;
            j         <= '0;
            j_hi      <= '0;
            i         <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            addr_x_o  <= '0;
            addr_y_o  <= '0;
            mac_clr_o <= 1'b0;
            mac_en_o  <= 1'b0;
            wr_z_o    <= 1'b0;
            addr_z_o  <= '0;
        end else begin
            // Memory returns data one cycle after the address, so enable trails READ.
            mac_en_o <= (state == READ);
            case (state)
                IDLE: begin
                    if (start_i) begin
                        sz_x   <= size_x_i;
                        sz_y   <= size_y_i;
                        i      <= '0;
                        busy_o <= 1'b1;
                        if (size_x_i == '0 || size_y_i == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state     <= INIT;
                            mac_clr_o <= 1'b1;
                        end
                    end
                end
                INIT: begin
                    mac_clr_o <= 1'b0;
                    j         <= AW'(j_lo_w);
                    j_hi      <= AW'(j_hi_w);
                    addr_x_o  <= AW'(j_lo_w);
                    addr_y_o  <= AW'(i - j_lo_w);
                    state     <= READ;
                end
                READ: begin
                    if (j == j_hi) begin
                        state <= FLUSH;
                    end else begin
                        j        <= j_inc;
                        addr_x_o <= j_inc;
                        addr_y_o <= AW'(i - ZW'(j_inc));
                    end
                end
                FLUSH: begin
                    wr_z_o   <= 1'b1;
                    addr_z_o <= i;
                    state    <= WRITE;
                end
                WRITE: begin
                    wr_z_o <= 1'b0;
                    if (i == last_i) begin
                        done_o <= 1'b1;
                        state  <= DONE;
                    end else begin
                        i         <= i + ZW'(1);
                        mac_clr_o <= 1'b1;
                        state     <= INIT;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    busy_o    <= 1'b0;
                    done_o    <= 1'b0;
                    mac_clr_o <= 1'b0;
                    mac_en_o  <= 1'b0;
                    wr_z_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_idx_sequencer.sv
// Bench for conv_idx_sequencer: per-cycle comparison against a trace built
// from the convolution index ranges, plus closed-form done timing.
module tb_conv_idx_sequencer;
    localparam int AW = 5;
    localparam int ZW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [AW-1:0] size_x_i;
    logic [AW-1:0] size_y_i;
    logic          busy_o;
    logic          done_o;
    logic [AW-1:0] addr_x_o;
    logic [AW-1:0] addr_y_o;
    logic          mac_clr_o;
    logic          mac_en_o;
    logic          wr_z_o;
    logic [ZW-1:0] addr_z_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit clr;
        bit en;
        bit wr;
        bit done;
        bit rd;
        int ax;
        int ay;
        int az;
    } cyc_t;

    cyc_t q[$];

    conv_idx_sequencer #(.AW(AW), .ZW(ZW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .size_x_i  (size_x_i),
        .size_y_i  (size_y_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .addr_x_o  (addr_x_o),
        .addr_y_o  (addr_y_o),
        .mac_clr_o (mac_clr_o),
        .mac_en_o  (mac_en_o),
        .wr_z_o    (wr_z_o),
        .addr_z_o  (addr_z_o)
    );

    always #5 clk = ~clk;

    // Expected per-cycle trace: clear, one read per term, flush, write, then done.
    task automatic build_model(input int sx, input int sy);
        cyc_t c;
        q.delete();
        if (sx == 0 || sy == 0) begin
            c = '{default: 0};
            c.done = 1'b1;
            q.push_back(c);
            return;
        end
        for (int i = 0; i <= sx + sy - 2; i++) begin
            int lo;
            int hi;
            lo = (i >= sy) ? i - sy + 1 : 0;
            hi = (i < sx - 1) ? i : sx - 1;
            c = '{default: 0};
            c.clr = 1'b1;
            q.push_back(c);
            for (int j = lo; j <= hi; j++) begin
                c = '{default: 0};
                c.rd = 1'b1;
                c.ax = j;
                c.ay = i - j;
                c.en = (j > lo);
                q.push_back(c);
            end
            c = '{default: 0};
            c.en = 1'b1;
            q.push_back(c);
            c = '{default: 0};
            c.wr = 1'b1;
            c.az = i;
            q.push_back(c);
        end
        c = '{default: 0};
        c.done = 1'b1;
        q.push_back(c);
    endtask

    task automatic run_job(input int sx, input int sy, input int noise_at, input string tag);
        int       done_cyc;
        int       exp_done;
        logic [4:0] obs;
        logic [4:0] expv;
        build_model(sx, sy);
        exp_done = (sx == 0 || sy == 0) ? 1 : sx * sy + 3 * (sx + sy - 1) + 1;
        done_cyc = -1;
        @(negedge clk);
        start_i  = 1'b1;
        size_x_i = AW'(sx);
        size_y_i = AW'(sy);
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            if (k == 0) start_i = 1'b0;
            if (k == noise_at) begin
                start_i  = 1'b1;
                size_x_i = 5'd5;
                size_y_i = 5'd5;
            end else if (k == noise_at + 1) begin
                start_i = 1'b0;
            end
            obs  = {busy_o, done_o, mac_clr_o, mac_en_o, wr_z_o};
            expv = {1'b1, q[k].done, q[k].clr, q[k].en, q[k].wr};
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL %s ctl cyc=%0d got busy/done/clr/en/wr=%b exp=%b", tag, k + 1, obs, expv);
            end
            if (q[k].rd) begin
                checks++;
                if ({addr_x_o, addr_y_o} !== {AW'(q[k].ax), AW'(q[k].ay)}) begin
                    errors++;
                    $display("FAIL %s addr_xy cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                             tag, k + 1, addr_x_o, addr_y_o, q[k].ax, q[k].ay);
                end
            end
            if (q[k].wr) begin
                checks++;
                if (addr_z_o !== ZW'(q[k].az)) begin
                    errors++;
                    $display("FAIL %s addr_z cyc=%0d got=%0d exp=%0d", tag, k + 1, addr_z_o, q[k].az);
                end
            end
            if (done_o === 1'b1 && done_cyc < 0) done_cyc = k + 1;
        end
        @(negedge clk);
        obs = {busy_o, done_o, mac_clr_o, mac_en_o, wr_z_o};
        checks++;
        if (obs !== 5'b0) begin
            errors++;
            $display("FAIL %s idle_after got=%b exp=00000", tag, obs);
        end
        checks++;
        if (done_cyc !== exp_done) begin
            errors++;
            $display("FAIL %s done_cycle got=%0d exp=%0d", tag, done_cyc, exp_done);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start_i  = 1'b0;
        size_x_i = '0;
        size_y_i = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_o, done_o, mac_clr_o, mac_en_o, wr_z_o, addr_x_o, addr_y_o, addr_z_o} !== '0) begin
            errors++;
            $display("FAIL reset outputs got busy=%b done=%b clr=%b en=%b wr=%b ax=%0d ay=%0d az=%0d exp all 0",
                     busy_o, done_o, mac_clr_o, mac_en_o, wr_z_o, addr_x_o, addr_y_o, addr_z_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_job(1, 1, -1, "s1x1");
        run_job(3, 2, -1, "s3x2");
        run_job(2, 3, -1, "s2x3");
    endtask

    task automatic test_max();
        run_job(31, 31, -1, "s31x31");
    endtask

    task automatic test_zero_size();
        run_job(0, 7, -1, "s0x7");
        run_job(5, 0, -1, "s5x0");
    endtask

    task automatic test_start_ignored();
        run_job(3, 2, 4, "ign_start");
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        start_i  = 1'b1;
        size_x_i = 5'd3;
        size_y_i = 5'd2;
        @(negedge clk);
        start_i = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy_o, done_o, mac_clr_o, mac_en_o, wr_z_o, addr_x_o, addr_y_o, addr_z_o} !== '0) begin
            errors++;
            $display("FAIL mid_reset outputs got busy=%b done=%b clr=%b en=%b wr=%b ax=%0d ay=%0d az=%0d exp all 0",
                     busy_o, done_o, mac_clr_o, mac_en_o, wr_z_o, addr_x_o, addr_y_o, addr_z_o);
        end
        rst = 1'b0;
        run_job(3, 2, -1, "after_rst");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 8; n++) begin
            int sx;
            int sy;
            sx = $urandom_range(0, 12);
            sy = $urandom_range(0, 12);
            if (n % 4 == 3) sx = 0;
            run_job(sx, sy, (n % 2 == 1) ? 2 : -1, $sformatf("rnd%0d_%0dx%0d", n, sx, sy));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero_size();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
